// File: rtl/local_design.sv
// Local-history branch predictor: per-PC history shift registers index a table
// of saturating counters whose MSB is the taken/not-taken prediction.
module local_design #(
  parameter int PC_WIDTH   = 10,
  parameter int HIST_WIDTH = 10,
  parameter int CTR_WIDTH  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] PC,
  input  logic                BranchTaken,
  output logic                BranchResult
);

  localparam int LHT_DEPTH = 1 << PC_WIDTH;
  localparam int LPT_DEPTH = 1 << HIST_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_MIN = '0;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

  logic [HIST_WIDTH-1:0] lht [LHT_DEPTH];
  logic [CTR_WIDTH-1:0]  lpt [LPT_DEPTH];

  logic [PC_WIDTH-1:0]   pc_p0;
  logic                  vld_p0;
  logic [HIST_WIDTH-1:0] lhtresult;
  logic [HIST_WIDTH-1:0] hist_p0;

  function automatic logic [CTR_WIDTH-1:0] ctr_sat(input logic [CTR_WIDTH-1:0] c,
                                                   input logic taken);
    logic [CTR_WIDTH-1:0] r;
    r = c;
    if (taken) begin
      if (c != CTR_MAX) r = c + CTR_ONE;
    end else begin
      if (c != CTR_MIN) r = c - CTR_ONE;
    end
    return r;
  endfunction

  // Prediction stage: reads pre-edge tables, so a same-cycle update is never bypassed
  always_comb begin
    lhtresult    = lht[PC];
    BranchResult = lpt[lhtresult][CTR_WIDTH-1];
    hist_p0      = lht[pc_p0];
  end

  // Training stage: the outcome arriving now belongs to the branch latched in pc_p0
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LHT_DEPTH; i++) lht[i] <= '0;
      for (int j = 0; j < LPT_DEPTH; j++) lpt[j] <= '0;
      pc_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (vld_p0) begin
        lpt[hist_p0] <= ctr_sat(lpt[hist_p0], BranchTaken);
        lht[pc_p0]   <= {hist_p0[HIST_WIDTH-2:0], BranchTaken};
      end
      pc_p0  <= PC;
      vld_p0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_local_design.sv
// Directed and randomized checks of local_design against an arithmetic model
// of the history/counter tables.
module tb_local_design;

  localparam int PCW  = 10;
  localparam int HW   = 10;
  localparam int CW   = 3;
  localparam int HMAX = (1 << HW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [PCW-1:0] PC = '0;
  logic           BranchTaken = 1'b0;
  logic           BranchResult;

  int total = 0;
  int bad   = 0;

  int lht_m [1 << PCW];
  int lpt_m [1 << HW];
  int pcprev_m = 0;
  bit prevv_m  = 0;

  local_design #(.PC_WIDTH(PCW), .HIST_WIDTH(HW), .CTR_WIDTH(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .PC          (PC),
    .BranchTaken (BranchTaken),
    .BranchResult(BranchResult)
  );

  always #5 clock = ~clock;

  function automatic bit predict(input int pc);
    return lpt_m[lht_m[pc]] >= (CMAX + 1) / 2;
  endfunction

  // One cycle: present pc/taken/reset, check the prediction, then clock the model.
  task automatic step(input int pc, input bit taken, input bit rst, input string tag);
    bit exp;
    int h;
    @(negedge clock);
    PC = pc[PCW-1:0];
    BranchTaken = taken;
    reset = rst;
    #1;
    exp = predict(pc);
    total++;
    assert (BranchResult === exp)
      else begin
        bad++;
        $error("FAIL %s pc=%0d observed=%b expected=%b", tag, pc, BranchResult, exp);
      end
    @(posedge clock);
    if (rst) begin
      foreach (lht_m[i]) lht_m[i] = 0;
      foreach (lpt_m[i]) lpt_m[i] = 0;
      pcprev_m = 0;
      prevv_m  = 0;
    end else begin
      if (prevv_m) begin
        h = lht_m[pcprev_m];
        lpt_m[h] = taken ? ((lpt_m[h] < CMAX) ? lpt_m[h] + 1 : CMAX)
                         : ((lpt_m[h] > 0) ? lpt_m[h] - 1 : 0);
        lht_m[pcprev_m] = ((h << 1) | int'(taken)) & HMAX;
      end
      pcprev_m = pc;
      prevv_m  = 1;
    end
  endtask

  task automatic chk_tables(input int pc, input string tag);
    int h;
    #1;
    h = lht_m[pc];
    total++;
    assert (int'(dut.lht[pc]) === h)
      else begin
        bad++;
        $error("FAIL %s_lht pc=%0d observed=%0d expected=%0d", tag, pc, dut.lht[pc], h);
      end
    total++;
    assert (int'(dut.lpt[h]) === lpt_m[h])
      else begin
        bad++;
        $error("FAIL %s_lpt idx=%0d observed=%0d expected=%0d", tag, h, dut.lpt[h], lpt_m[h]);
      end
  endtask

  initial begin
    foreach (lht_m[i]) lht_m[i] = 0;
    foreach (lpt_m[i]) lpt_m[i] = 0;

    // reset, then every PC predicts not-taken
    step(0, 0, 1, "rst");
    step(0, 0, 1, "rst");
    step(20, 0, 0, "pc20_first");
    step(10, 1, 0, "pc10");
    chk_tables(20, "after2");
    total++;
    assert (dut.pc_p0 === 10'd10)
      else begin
        bad++;
        $error("FAIL pcprev observed=%0d expected=10", dut.pc_p0);
      end

    // alternating 10/20, all taken
    for (int k = 0; k < 5; k++) step((k % 2 == 0) ? 20 : 10, 1, 0, "alt");
    chk_tables(20, "alt20");
    chk_tables(10, "alt10");
    total++;
    assert (int'(dut.lpt[1]) === lpt_m[1])
      else begin
        bad++;
        $error("FAIL alt_lpt1 observed=%0d expected=%0d", dut.lpt[1], lpt_m[1]);
      end

    // held PC 5, always taken: history fills, counter saturates
    step(5, 0, 1, "rst2");
    for (int k = 0; k < 22; k++) begin
      step(5, 1, 0, "sat");
      if (k == 11 || k == 15 || k == 21) chk_tables(5, "sat");
    end
    step(5, 0, 0, "one_nt");
    chk_tables(5, "one_nt");
    step(5, 1, 0, "after_nt");

    // mid-operation reset discards pending update; first post-reset outcome ignored
    step(5, 1, 1, "midrst");
    step(5, 1, 0, "post_rst");
    step(5, 1, 0, "post_rst2");
    chk_tables(5, "post_rst");

    // underflow on PC 7
    step(7, 0, 1, "rst3");
    for (int k = 0; k < 6; k++) step(7, 0, 0, "uflow");
    chk_tables(7, "uflow");

    // randomized traffic over a small PC set so tables train and alias
    step(0, 0, 1, "rst4");
    for (int k = 0; k < 600; k++) begin
      int pc;
      bit t, r;
      pc = int'($urandom_range(0, 7));
      t  = ($urandom_range(0, 3) != 0) ? (pc[0] | pc[1]) : ~(pc[0] | pc[1]);
      r  = ($urandom_range(0, 199) == 0);
      step(pc, t, r, "rand");
      if (k % 50 == 49) chk_tables(pc, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
